// File: rtl/aes_sched_pkg.sv
// Shared AES definitions: scheduler FSM states, mode constants and block width.
package aes_sched_pkg;

  localparam int unsigned DATA_W = 128;

  localparam logic ENCRYPT = 1'b1;
  localparam logic DECRYPT = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/aes_sched_rr_arbiter.sv
// Round-robin winner selection: first requester at or above ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int unsigned IW = $clog2(NUM_REQ);

  // Scan farthest offset first so the closest requester to ptr wins last.
  always_comb begin
    int unsigned j;
    grant = '0;
    idx   = '0;
    j     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = (32'(ptr) + (NUM_REQ - 1 - k)) % NUM_REQ;
      if (req[IW'(j)]) begin
        grant         = '0;
        grant[IW'(j)] = 1'b1;
        idx           = IW'(j);
      end
    end
  end

endmodule

// File: rtl/aes_sched.sv
// Round-robin scheduler sharing one AES core among NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining AES_SCHED_TIMEOUT_EN.
module aes_sched
  import aes_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic [NUM_REQ-1:0]           req_valid_in,
  output logic [NUM_REQ-1:0]           req_ready_out,
  input  logic [NUM_REQ-1:0]           req_mode_in,
  input  logic [NUM_REQ*128-1:0]       req_data_in,
  output logic [NUM_REQ-1:0]           resp_valid_out,
  input  logic [NUM_REQ-1:0]           resp_ready_in,
  output logic [127:0]                 resp_data_out,
  output logic                         resp_err_out,
  output logic                         core_init_out,
  output logic                         core_mode_out,
  output logic [127:0]                 core_data_out,
  input  logic                         core_valid_in,
  input  logic [127:0]                 core_data_in,
  output logic                         busy_out,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id_out
);

  localparam int unsigned IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_cfg_err
    $error("aes_sched: illegal NUM_REQ or TIMEOUT_CYCLES");
  end

  state_t            state_q, state_d;
  logic [IW-1:0]     rr_ptr_q, id_q, arb_idx, next_ptr;
  logic [NUM_REQ-1:0] arb_grant;
  logic [DATA_W-1:0] data_q, result_q, sel_data;
  logic              mode_q, accept, resp_done, timeout_hit;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req_valid_in),
    .ptr   (rr_ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  // Ready is only offered in IDLE and never while reset is held.
  assign req_ready_out  = (state_q == IDLE && rst_in) ? arb_grant : '0;
  assign accept         = |(req_ready_out & req_valid_in);
  assign resp_done      = (state_q == RESP) && resp_ready_in[id_q];
  assign next_ptr       = (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;

  assign resp_valid_out = (state_q == RESP) ? (NUM_REQ'(1) << id_q) : '0;
  assign resp_data_out  = result_q;
  assign core_init_out  = (state_q == LAUNCH);
  assign core_mode_out  = mode_q;
  assign core_data_out  = data_q;
  assign busy_out       = (state_q != IDLE);
  assign grant_id_out   = (state_q == IDLE) ? rr_ptr_q : id_q;

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == IW'(i)) sel_data = req_data_in[i*DATA_W +: DATA_W];
    end
  end

`ifdef AES_SCHED_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] tmo_cnt_q;
  logic          err_q;

  assign timeout_hit  = (state_q == WAIT) && (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign resp_err_out = err_q;

  // Watchdog counts WAIT cycles; a core result on the limit cycle still wins.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (state_q == LAUNCH)    tmo_cnt_q <= '0;
      else if (state_q == WAIT) tmo_cnt_q <= tmo_cnt_q + 1'b1;
      if (accept)                                    err_q <= 1'b0;
      else if (timeout_hit && !core_valid_in)        err_q <= 1'b1;
    end
  end
`else
  assign timeout_hit  = 1'b0;
  assign resp_err_out = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = LAUNCH;
      LAUNCH:  state_d = WAIT;
      WAIT:    if (core_valid_in || timeout_hit) state_d = RESP;
      RESP:    if (resp_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch and result register; core results outside WAIT are dropped.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rr_ptr_q <= '0;
      id_q     <= '0;
      data_q   <= '0;
      mode_q   <= DECRYPT;
      result_q <= '0;
    end else begin
      if (accept) begin
        data_q   <= sel_data;
        mode_q   <= (req_mode_in[arb_idx] == ENCRYPT) ? ENCRYPT : DECRYPT;
        id_q     <= arb_idx;
        rr_ptr_q <= next_ptr;
      end
      if (state_q == WAIT) begin
        if (core_valid_in)    result_q <= core_data_in;
        else if (timeout_hit) result_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_aes_sched.sv
// Randomized self-checking bench for aes_sched against a transaction-level model.
module tb_aes_sched;
  import aes_sched_pkg::*;

  localparam int NR  = 2;
  localparam int TMO = 8;
`ifdef AES_SCHED_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic [NR-1:0]     req_valid_in, req_ready_out, req_mode_in;
  logic [NR*128-1:0] req_data_in;
  logic [NR-1:0]     resp_valid_out, resp_ready_in;
  logic [127:0]      resp_data_out, core_data_out, core_data_in;
  logic              resp_err_out, core_init_out, core_mode_out, core_valid_in, busy_out;
  logic [0:0]        grant_id_out;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: pending requests, round-robin pointer, last delivered result.
  int            mptr;
  logic [NR-1:0] pending;
  logic [127:0]  req_data [NR];
  logic          req_mode [NR];
  logic [127:0]  last_result;

  aes_sched #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .req_valid_in   (req_valid_in),
    .req_ready_out  (req_ready_out),
    .req_mode_in    (req_mode_in),
    .req_data_in    (req_data_in),
    .resp_valid_out (resp_valid_out),
    .resp_ready_in  (resp_ready_in),
    .resp_data_out  (resp_data_out),
    .resp_err_out   (resp_err_out),
    .core_init_out  (core_init_out),
    .core_mode_out  (core_mode_out),
    .core_data_out  (core_data_out),
    .core_valid_in  (core_valid_in),
    .core_data_in   (core_data_in),
    .busy_out       (busy_out),
    .grant_id_out   (grant_id_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Stand-in core transform; the bench plays the core.
  function automatic logic [127:0] core_fn(input logic [127:0] d, input logic m);
    return m ? ({d[95:0], d[127:96]} ^ {4{32'h9e3779b9}}) : ~d;
  endfunction

  task automatic drive_reqs();
    req_valid_in = pending;
    for (int i = 0; i < NR; i++) begin
      req_data_in[i*128 +: 128] = req_data[i];
      req_mode_in[i]            = req_mode[i];
    end
  endtask

  task automatic raise(input int i);
    pending[i]  = 1'b1;
    req_data[i] = {$urandom, $urandom, $urandom, $urandom};
    req_mode[i] = 1'($urandom_range(0, 1));
  endtask

  // One full transaction; entered and left just after a falling edge.
  task automatic run_txn(input int lat, input int hold, input bit fixed, input logic [127:0] fixed_res);
    int            w;
    logic [NR-1:0] oh;
    logic [127:0]  exp_res;
    logic          exp_err;
    w = -1;
    for (int k = 0; k < NR; k++) begin
      if (w < 0 && pending[(mptr + k) % NR]) w = (mptr + k) % NR;
    end
    if (w < 0) begin
      check("no_pending_request", 128'(1), 128'(0));
      return;
    end
    oh    = '0;
    oh[w] = 1'b1;
    drive_reqs();
    #1;
    check("idle_busy", 128'(busy_out), 128'(0));
    check("idle_grant_id", 128'(grant_id_out), 128'(mptr));
    check("idle_ready", 128'(req_ready_out), 128'(oh));
    @(posedge clk_in);
    @(negedge clk_in);
    pending[w] = 1'b0;
    drive_reqs();
    mptr = (w + 1) % NR;
    #1;
    check("launch_init", 128'(core_init_out), 128'(1));
    check("launch_busy", 128'(busy_out), 128'(1));
    check("launch_grant_id", 128'(grant_id_out), 128'(w));
    check("launch_ready", 128'(req_ready_out), 128'(0));
    check("launch_core_data", core_data_out, req_data[w]);
    check("launch_core_mode", 128'(core_mode_out), 128'(req_mode[w]));

    if (TMO_EN && lat > TMO) begin
      exp_res = '0;
      exp_err = 1'b1;
      for (int c = 1; c <= TMO; c++) begin
        @(negedge clk_in);
        #1;
        check("tmo_wait_noresp", 128'(resp_valid_out), 128'(0));
      end
      @(negedge clk_in);
    end else begin
      exp_res = fixed ? fixed_res : core_fn(req_data[w], req_mode[w]);
      exp_err = 1'b0;
      for (int c = 1; c <= lat; c++) begin
        @(negedge clk_in);
        #1;
        check("wait_noresp", 128'(resp_valid_out), 128'(0));
        if (c == 1) begin
          check("wait_init_low", 128'(core_init_out), 128'(0));
          check("wait_core_data", core_data_out, req_data[w]);
        end
        if (c == lat) begin
          core_valid_in = 1'b1;
          core_data_in  = exp_res;
        end
      end
      @(negedge clk_in);
      core_valid_in = 1'b0;
      core_data_in  = ~exp_res;
    end
    #1;
    check("resp_valid", 128'(resp_valid_out), 128'(oh));
    check("resp_data", resp_data_out, exp_res);
    check("resp_err", 128'(resp_err_out), 128'(exp_err));

    resp_ready_in = ~oh;
    for (int h = 0; h < hold; h++) begin
      if (h == 0) core_valid_in = 1'b1;
      @(negedge clk_in);
      core_valid_in = 1'b0;
      #1;
      check("hold_resp_valid", 128'(resp_valid_out), 128'(oh));
      check("hold_resp_data", resp_data_out, exp_res);
      check("hold_no_ready", 128'(req_ready_out), 128'(0));
    end
    resp_ready_in = oh;
    @(negedge clk_in);
    resp_ready_in = '0;
    #1;
    check("done_busy", 128'(busy_out), 128'(0));
    check("done_resp_valid", 128'(resp_valid_out), 128'(0));
    check("done_resp_data", resp_data_out, exp_res);
    last_result = exp_res;
  endtask

  initial begin
    rst_in        = 1'b0;
    mptr          = 0;
    last_result   = '0;
    resp_ready_in = '0;
    core_valid_in = 1'b0;
    core_data_in  = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < NR; i++) raise(i);
    drive_reqs();
    repeat (3) @(negedge clk_in);
    #1;
    check("rst_ready", 128'(req_ready_out), 128'(0));
    check("rst_busy", 128'(busy_out), 128'(0));
    check("rst_resp_valid", 128'(resp_valid_out), 128'(0));
    check("rst_resp_data", resp_data_out, 128'(0));
    check("rst_core_init", 128'(core_init_out), 128'(0));
    check("rst_core_data", core_data_out, 128'(0));
    check("rst_grant_id", 128'(grant_id_out), 128'(0));
    pending = '0;
    drive_reqs();
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);

    // Single known-answer request from requester 0.
    pending[0]  = 1'b1;
    req_data[0] = 128'h3243f6a8885a308d313198a2e0370734;
    req_mode[0] = ENCRYPT;
    run_txn(10, 0, 1'b1, 128'h3925841d02dc09fbdc118597196a0b32);

    // Fairness: pointer now at 1, so requester 1 first, then 0.
    raise(0);
    raise(1);
    run_txn(3, 5, 1'b0, '0);
    run_txn(4, 0, 1'b0, '0);
    raise(0);
    raise(1);
    run_txn(2, 0, 1'b0, '0);
    run_txn(2, 0, 1'b0, '0);

    // Core result while idle must be ignored.
    core_valid_in = 1'b1;
    core_data_in  = ~last_result;
    @(negedge clk_in);
    core_valid_in = 1'b0;
    #1;
    check("idle_core_valid_busy", 128'(busy_out), 128'(0));
    check("idle_core_valid_resp", 128'(resp_valid_out), 128'(0));
    check("idle_core_valid_data", resp_data_out, last_result);

    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pending[i] && $urandom_range(0, 1) == 1) raise(i);
      end
      if (pending == '0) raise(int'($urandom_range(0, NR - 1)));
      run_txn(int'($urandom_range(1, 11)), int'($urandom_range(0, 3)), 1'b0, '0);
    end

    // Reset dropped mid-WAIT abandons the transaction.
    raise(0);
    drive_reqs();
    @(posedge clk_in);
    @(negedge clk_in);
    pending = 2'b10;
    drive_reqs();
    @(negedge clk_in);
    #2;
    rst_in = 1'b0;
    #1;
    check("async_rst_busy", 128'(busy_out), 128'(0));
    check("async_rst_ready", 128'(req_ready_out), 128'(0));
    check("async_rst_core_data", core_data_out, 128'(0));
    check("async_rst_core_mode", 128'(core_mode_out), 128'(0));
    check("async_rst_resp_data", resp_data_out, 128'(0));
    check("async_rst_grant_id", 128'(grant_id_out), 128'(0));
    @(negedge clk_in);
    pending = '0;
    drive_reqs();
    rst_in      = 1'b1;
    mptr        = 0;
    last_result = '0;
    @(negedge clk_in);
    core_valid_in = 1'b1;
    core_data_in  = {4{32'hdeadbeef}};
    @(negedge clk_in);
    core_valid_in = 1'b0;
    #1;
    check("post_rst_no_resp", 128'(resp_valid_out), 128'(0));
    check("post_rst_busy", 128'(busy_out), 128'(0));
    check("post_rst_data", resp_data_out, 128'(0));

`ifdef AES_SCHED_TIMEOUT_EN
    raise(1);
    run_txn(TMO + 5, 2, 1'b0, '0);
    raise(0);
    run_txn(TMO, 0, 1'b0, '0);
`endif
    raise(0);
    raise(1);
    run_txn(5, 1, 1'b0, '0);
    run_txn(1, 0, 1'b0, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_sched.md
AES_SCHED -- requirements
Module: aes_sched

Interface
REQ-001 Parameter NUM_REQ, default 2, SHALL set the number of requesters sharing one AES core (legal range 2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 64, SHALL set the WAIT-state watchdog limit in clock cycles (used only when AES_SCHED_TIMEOUT_EN is defined).
REQ-003 Ports SHALL be:
- clk_in  input  1  sole clock, all state on rising edge.
- rst_in  input  1  reset, asynchronous, active-low.
- req_valid_in  input  NUM_REQ  per-requester block-valid.
- req_ready_out  output  NUM_REQ  per-requester accept (at most one bit high).
- req_mode_in  input  NUM_REQ  per-requester mode, 1=encrypt, 0=decrypt.
- req_data_in  input  NUM_REQ*128  per-requester plaintext/ciphertext; requester i occupies bits [128*i+127:128*i].
- resp_valid_out  output  NUM_REQ  per-requester result-valid (at most one bit high).
- resp_ready_in  input  NUM_REQ  per-requester result-accept.
- resp_data_out  output  128  shared result bus.
- resp_err_out  output  1  result is a timeout abort.
- core_init_out  output  1  single-cycle start pulse to the AES core.
- core_mode_out  output  1  mode to the core.
- core_data_out  output  128  block to the core.
- core_valid_in  input  1  core result-valid.
- core_data_in  input  128  core result.
- busy_out  output  1  high in any state other than IDLE.
- grant_id_out  output  $clog2(NUM_REQ)  index of current owner.

Function
REQ-004 The FSM SHALL have states IDLE, LAUNCH, WAIT, RESP.
REQ-005 In IDLE, the winner SHALL be the first i with req_valid_in[i]=1, scanning from rr_ptr upward, wrapping modulo NUM_REQ; req_ready_out SHALL be combinationally one-hot on the winner, else zero.
REQ-006 On a handshake (valid and ready both high), the block SHALL latch data, mode and id, set rr_ptr to (id+1) mod NUM_REQ, and enter LAUNCH.
REQ-007 In LAUNCH, core_init_out SHALL be 1 for exactly one cycle, then the FSM SHALL enter WAIT.
REQ-008 core_data_out and core_mode_out SHALL hold the latched values from LAUNCH until WAIT exits.
REQ-009 In WAIT, core_valid_in=1 SHALL latch core_data_in into the result register and move the FSM to RESP.
REQ-010 core_valid_in in any state other than WAIT SHALL be ignored.
REQ-011 In RESP, resp_valid_out[id] SHALL be 1 with resp_data_out stable until resp_ready_in[id]=1.
- The handshake cycle SHALL return the FSM to IDLE.
- resp_ready_in bits of non-owners SHALL be ignored.
REQ-012 The new-request handshake SHALL NOT occur in the cycle that completes RESP.
- Back-to-back spacing is therefore at least 4 cycles plus the core latency.
REQ-013 Requests held by non-granted requesters SHALL remain pending with ready low.
- Round-robin SHALL guarantee service within NUM_REQ grants.
REQ-014 grant_id_out SHALL equal the latched id outside IDLE and rr_ptr in IDLE.

Reset
REQ-015 While rst_in=0, the block SHALL be in IDLE with rr_ptr=0, and all outputs, result and latch registers SHALL be 0.
REQ-016 Reset asserted mid-operation SHALL abandon the transaction without any response; a core result arriving after reset release SHALL be ignored per REQ-010.

Configuration
REQ-017 With macro AES_SCHED_TIMEOUT_EN defined, a counter SHALL clear in LAUNCH and increment each WAIT cycle.
- On reaching TIMEOUT_CYCLES without core_valid_in, the FSM SHALL enter RESP with resp_data_out=0 and resp_err_out=1.
- A valid on the limit cycle SHALL take priority and produce a normal response.
REQ-018 Without AES_SCHED_TIMEOUT_EN, no counter SHALL exist, resp_err_out SHALL be tied 0, and WAIT SHALL be unbounded.

Structure
REQ-019 The FSM state enum and the ENCRYPT/DECRYPT mode constants SHALL live in the shared AES definitions package.
REQ-020 The round-robin winner selection SHALL be the sub-module rr_arbiter (inputs: request vector, pointer; outputs: one-hot grant, index).

Verification
REQ-021 The bench SHALL cover:
- Single request: req0 valid, data=128'h3243f6a8885a308d313198a2e0370734, mode=1, core returns 128'h3925841d02dc09fbdc118597196a0b32 after 10 cycles -> init pulse 1 cycle after accept; resp_valid_out=2'b01 with that data; busy_out falls after resp handshake.
- Simultaneous req0 and req1 from reset -> req0 served first, then req1; a third round with both valid -> req0 again.
- resp_ready_in held 0 for 5 cycles -> resp_valid_out and resp_data_out stable throughout; no new ready is granted.
- core_valid_in pulsed in IDLE and in RESP -> no state change, result unchanged.
- rst_in dropped in WAIT -> all outputs 0 immediately (asynchronously); a later core_valid_in produces no response.
- AES_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=8, core never valid -> RESP after 8 WAIT cycles, resp_err_out=1, resp_data_out=0.
